eval_dispatch: RTL and testbench

EVAL_DISPATCH -- requirements
Module: eval_dispatch

---
 rtl/eval_dispatch.sv | 157 +++++++++++++++
 tb/tb_eval_dispatch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eval_dispatch.sv
// eval_dispatch: accepts one position request at a time, starts the evaluator,
// waits for its result (or gives up after a bounded wait), retires the
// evaluator's result and holds the response until downstream takes it.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module eval_dispatch #(
  parameter int EVAL_WIDTH     = 0,
  parameter int TAG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  // A zero-width result cannot be declared; fall back to one bit until the
  // instantiating level supplies the real width.
  localparam int EW = (EVAL_WIDTH > 0) ? EVAL_WIDTH : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [`BOARD_WIDTH-1:0]       req_board,
  input  logic [3:0]                    req_castle_mask,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  output logic                          board_valid,
  output logic [`BOARD_WIDTH-1:0]       board,
  output logic [3:0]                    castle_mask,
  output logic                          clear_eval,
  input  logic signed [EW-1:0]          eval_mg,
  input  logic                          eval_valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic signed [EW-1:0]          rsp_eval,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic                          rsp_timeout,
  output logic [15:0]                   eval_count
);

  // Wait counter only has to reach TIMEOUT_CYCLES-1.
  localparam int             CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  LP_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_RESPOND
  } state_t;

  state_t                        r_state;
  logic                          r_req_ready;
  logic [`BOARD_WIDTH-1:0]       r_board;
  logic [3:0]                    r_castle_mask;
  logic [TAG_WIDTH-1:0]          r_tag;
  logic                          r_board_valid;
  logic                          r_clear_eval;
  logic                          r_rsp_valid;
  logic signed [EW-1:0]          r_rsp_eval;
  logic                          r_rsp_timeout;
  logic [15:0]                   r_eval_count;
  logic [CW-1:0]                 r_wait_cnt;

  logic                          w_accept;

  // A request is taken only when the registered ready is already showing,
  // so the first cycle out of reset cannot accept anything.
  assign w_accept = req_valid && r_req_ready;

  // Dispatcher FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b0;
      r_board       <= '0;
      r_castle_mask <= '0;
      r_tag         <= '0;
      r_board_valid <= 1'b0;
      r_clear_eval  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_eval    <= '0;
      r_rsp_timeout <= 1'b0;
      r_eval_count  <= '0;
      r_wait_cnt    <= '0;
    end else begin
      // Start and retire strobes are single-cycle by construction.
      r_board_valid <= 1'b0;
      r_clear_eval  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Board and castle rights stay frozen until the next accept,
            // which covers the evaluator's mid-pipeline castle sampling.
            r_board       <= req_board;
            r_castle_mask <= req_castle_mask;
            r_tag         <= req_tag;
            r_req_ready   <= 1'b0;
            r_board_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the final wait cycle still wins over timeout.
          if (eval_valid) begin
            r_rsp_eval    <= eval_mg;
            r_rsp_timeout <= 1'b0;
            r_clear_eval  <= 1'b1;
            r_state       <= S_CLEAR;
          end else if (r_wait_cnt == LP_LAST) begin
            r_rsp_eval    <= '0;
            r_rsp_timeout <= 1'b1;
            r_clear_eval  <= 1'b1;
            r_state       <= S_CLEAR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_CLEAR: begin
          if (!r_rsp_timeout) begin
            r_eval_count <= r_eval_count + 16'd1;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign board_valid = r_board_valid;
  assign board       = r_board;
  assign castle_mask = r_castle_mask;
  assign clear_eval  = r_clear_eval;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_eval    = r_rsp_eval;
  assign rsp_tag     = r_tag;
  assign rsp_timeout = r_rsp_timeout;
  assign eval_count  = r_eval_count;

endmodule

// File: tb/tb_eval_dispatch.sv
// Directed bench for eval_dispatch: the bench plays both the upstream
// requester and the evaluator, and checks every handshake cycle by cycle.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_eval_dispatch;

  localparam int EW = 16;
  localparam int TW = 8;
  localparam int TO = 64;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [`BOARD_WIDTH-1:0]  req_board;
  logic [3:0]               req_castle_mask;
  logic [TW-1:0]            req_tag;
  logic                     board_valid;
  logic [`BOARD_WIDTH-1:0]  board;
  logic [3:0]               castle_mask;
  logic                     clear_eval;
  logic signed [EW-1:0]     eval_mg;
  logic                     eval_valid;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic signed [EW-1:0]     rsp_eval;
  logic [TW-1:0]            rsp_tag;
  logic                     rsp_timeout;
  logic [15:0]              eval_count;

  int errors = 0;
  int checks = 0;

  eval_dispatch #(
    .EVAL_WIDTH     (EW),
    .TAG_WIDTH      (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_board       (req_board),
    .req_castle_mask (req_castle_mask),
    .req_tag         (req_tag),
    .board_valid     (board_valid),
    .board           (board),
    .castle_mask     (castle_mask),
    .clear_eval      (clear_eval),
    .eval_mg         (eval_mg),
    .eval_valid      (eval_valid),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_eval        (rsp_eval),
    .rsp_tag         (rsp_tag),
    .rsp_timeout     (rsp_timeout),
    .eval_count      (eval_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset with the clock running; outputs checked before any edge.
  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_board = '0; req_castle_mask = '0;
    req_tag = '0; eval_mg = '0; eval_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (board_valid !== 1'b0) begin errors++; $display("FAIL rst_board_valid got=%b exp=0", board_valid); end
    checks++; if (clear_eval !== 1'b0)  begin errors++; $display("FAIL rst_clear_eval got=%b exp=0", clear_eval); end
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_timeout got=%b exp=0", rsp_timeout); end
    checks++; if (rsp_eval !== 16'sd0)  begin errors++; $display("FAIL rst_rsp_eval got=%0d exp=0", rsp_eval); end
    checks++; if (rsp_tag !== 8'h00)    begin errors++; $display("FAIL rst_rsp_tag got=%h exp=00", rsp_tag); end
    checks++; if (eval_count !== 16'd0) begin errors++; $display("FAIL rst_eval_count got=%0d exp=0", eval_count); end
    checks++; if (board !== '0)         begin errors++; $display("FAIL rst_board got=%h exp=0", board); end
    checks++; if (castle_mask !== 4'h0) begin errors++; $display("FAIL rst_castle got=%h exp=0", castle_mask); end
    tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_held_req_ready got=%b exp=0", req_ready); end
    reset = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_req_ready got=%b exp=0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_cycle_req_ready got=%b exp=1", req_ready); end
    $display("reset: outputs cleared, req_ready rises one cycle after release");
  endtask

  // One complete transaction. lat = cycles from the board_valid cycle to the
  // cycle eval_valid is presented (0 = evaluator never answers). hold = number
  // of RESPOND cycles before rsp_ready is given.
  task automatic run_txn(input logic [TW-1:0] tag, input logic [`BOARD_WIDTH-1:0] brd,
                         input logic [3:0] cm, input int lat, input logic signed [EW-1:0] val,
                         input int hold, input logic exp_to, input logic [15:0] exp_cnt,
                         input string nm);
    int n;
    int ecl;
    logic signed [EW-1:0] exp_eval;
    exp_eval = exp_to ? 16'sd0 : val;
    // The WAIT counter runs 0..TO-1, so the last chance is TO cycles after ISSUE.
    ecl = exp_to ? (TO + 1) : (lat + 1);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout got=%b exp=1", nm, req_ready); end
    req_valid = 1'b1; req_tag = tag; req_board = brd; req_castle_mask = cm;
    tick();
    req_valid = 1'b0; req_board = '0; req_castle_mask = '0; req_tag = '0;
    checks++; if (board_valid !== 1'b1) begin errors++; $display("FAIL %s issue_board_valid got=%b exp=1", nm, board_valid); end
    checks++; if (board !== brd)        begin errors++; $display("FAIL %s issue_board got=%h exp=%h", nm, board, brd); end
    checks++; if (castle_mask !== cm)   begin errors++; $display("FAIL %s issue_castle got=%h exp=%h", nm, castle_mask, cm); end
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL %s issue_req_ready got=%b exp=0", nm, req_ready); end
    for (int c = 1; c <= ecl; c++) begin
      tick();
      if (c < ecl) begin
        checks++;
        if (board_valid !== 1'b0 || clear_eval !== 1'b0 || board !== brd || castle_mask !== cm) begin
          errors++;
          $display("FAIL %s wait_cycle%0d bv=%b clr=%b board=%h cm=%h exp bv=0 clr=0 board=%h cm=%h",
                   nm, c, board_valid, clear_eval, board, castle_mask, brd, cm);
        end
      end else begin
        checks++; if (clear_eval !== 1'b1) begin errors++; $display("FAIL %s clear_pulse cyc%0d got=%b exp=1", nm, c, clear_eval); end
        checks++; if (board !== brd || castle_mask !== cm) begin errors++; $display("FAIL %s clear_hold board=%h cm=%h exp %h %h", nm, board, castle_mask, brd, cm); end
        eval_valid = 1'b0;
        eval_mg = '0;
      end
      if (lat > 0 && c == lat) begin
        eval_valid = 1'b1;
        eval_mg = val;
      end
    end
    tick();
    checks++; if (clear_eval !== 1'b0)     begin errors++; $display("FAIL %s clear_single got=%b exp=0", nm, clear_eval); end
    checks++; if (rsp_valid !== 1'b1)      begin errors++; $display("FAIL %s rsp_valid got=%b exp=1", nm, rsp_valid); end
    checks++; if (rsp_eval !== exp_eval)   begin errors++; $display("FAIL %s rsp_eval got=%0d exp=%0d", nm, rsp_eval, exp_eval); end
    checks++; if (rsp_tag !== tag)         begin errors++; $display("FAIL %s rsp_tag got=%h exp=%h", nm, rsp_tag, tag); end
    checks++; if (rsp_timeout !== exp_to)  begin errors++; $display("FAIL %s rsp_timeout got=%b exp=%b", nm, rsp_timeout, exp_to); end
    checks++; if (eval_count !== exp_cnt)  begin errors++; $display("FAIL %s eval_count got=%0d exp=%0d", nm, eval_count, exp_cnt); end
    for (int h = 1; h < hold; h++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_eval !== exp_eval || rsp_tag !== tag ||
          rsp_timeout !== exp_to || req_ready !== 1'b0 || clear_eval !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d v=%b e=%0d t=%h to=%b rdy=%b clr=%b exp v=1 e=%0d t=%h to=%b rdy=0 clr=0",
                 nm, h, rsp_valid, rsp_eval, rsp_tag, rsp_timeout, req_ready, clear_eval, exp_eval, tag, exp_to);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s idle_rsp_valid got=%b exp=0", nm, rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s idle_req_ready got=%b exp=1", nm, req_ready); end
    $display("%s: tag=%h eval=%0d timeout=%b count=%0d", nm, rsp_tag, rsp_eval, rsp_timeout, eval_count);
  endtask

  // Result 11 cycles after the start pulse, response held off for 5 cycles.
  task automatic test_basic();
    run_txn(8'h2A, 64'h0123_4567_89AB_CDEF, 4'hB, 11, -16'sd37, 5, 1'b0, 16'd1, "basic");
  endtask

  // Evaluator silent: 64 wait cycles then a flushing clear and a timeout response.
  task automatic test_timeout();
    run_txn(8'h11, 64'hFFFF_0000_1234_5678, 4'h3, 0, 16'sd0, 1, 1'b1, 16'd1, "timeout");
  endtask

  // Result first seen on the final wait cycle must beat the timeout.
  task automatic test_boundary();
    run_txn(8'h77, 64'h8000_0000_0000_0001, 4'h6, TO, 16'sd100, 2, 1'b0, 16'd2, "boundary");
  endtask

  // Reset dropped mid-WAIT: everything clears at once, nothing trails afterwards.
  task automatic test_reset_mid();
    req_valid = 1'b1; req_tag = 8'h5C; req_board = 64'hDEAD_BEEF_0000_0042; req_castle_mask = 4'hF;
    tick();
    req_valid = 1'b0; req_board = '0; req_castle_mask = '0; req_tag = '0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0 || board_valid !== 1'b0 || clear_eval !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl rdy=%b bv=%b clr=%b rv=%b exp all 0", req_ready, board_valid, clear_eval, rsp_valid);
    end
    checks++; if (eval_count !== 16'd0 || rsp_tag !== 8'h00 || board !== '0 || castle_mask !== 4'h0) begin
      errors++; $display("FAIL midrst_data cnt=%0d tag=%h board=%h cm=%h exp all 0", eval_count, rsp_tag, board, castle_mask);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (clear_eval !== 1'b0 || rsp_valid !== 1'b0 || board_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet cyc%0d clr=%b rv=%b bv=%b exp 0 0 0", i, clear_eval, rsp_valid, board_valid);
      end
    end
    $display("reset_mid: in-flight request abandoned silently");
    run_txn(8'h5D, 64'h0000_0000_FFFF_0000, 4'h9, 3, 16'sd250, 1, 1'b0, 16'd1, "after_reset");
  endtask

  // Stray evaluator pulse in IDLE, then two requests with no gap between them.
  task automatic test_back_to_back();
    eval_valid = 1'b1; eval_mg = 16'sd55;
    tick();
    eval_valid = 1'b0; eval_mg = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready !== 1'b1 || clear_eval !== 1'b0 || rsp_valid !== 1'b0 || board_valid !== 1'b0 || eval_count !== 16'd1) begin
        errors++;
        $display("FAIL stray cyc%0d rdy=%b clr=%b rv=%b bv=%b cnt=%0d exp 1 0 0 0 1",
                 i, req_ready, clear_eval, rsp_valid, board_valid, eval_count);
      end
      tick();
    end
    run_txn(8'hA1, 64'h1111_2222_3333_4444, 4'h1, 1, -16'sd1, 1, 1'b0, 16'd2, "b2b_first");
    run_txn(8'hA2, 64'h5555_6666_7777_8888, 4'h2, 4, 16'sd32767, 1, 1'b0, 16'd3, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1, "watchdog");
  end

endmodule
